// File: rtl/ysyx_24110006_scoreboard_if.sv
// Decode/execute/writeback signals seen by the register scoreboard.
// The master side is the pipeline; the slave side is the scoreboard.
interface ysyx_24110006_scoreboard_if;
    logic       i_dec_valid;
    logic [4:0] i_rs1;
    logic [4:0] i_rs2;
    logic [4:0] i_rd;
    logic       i_rs1_used;
    logic       i_rs2_used;
    logic       i_rd_wen;
    logic       i_serialize;
    logic       i_exu_ready;
    logic       i_flush;
    logic       i_wb_valid;
    logic [4:0] i_wb_rd;
    logic       i_wb_wen;
    logic       o_stall;
    logic       o_issue;
    logic [2:0] o_inflight;
    logic       o_draining;
    logic       o_err;

    modport master (
        output i_dec_valid, i_rs1, i_rs2, i_rd, i_rs1_used, i_rs2_used, i_rd_wen,
        output i_serialize, i_exu_ready, i_flush, i_wb_valid, i_wb_rd, i_wb_wen,
        input  o_stall, o_issue, o_inflight, o_draining, o_err
    );

    modport slave (
        input  i_dec_valid, i_rs1, i_rs2, i_rd, i_rs1_used, i_rs2_used, i_rd_wen,
        input  i_serialize, i_exu_ready, i_flush, i_wb_valid, i_wb_rd, i_wb_wen,
        output o_stall, o_issue, o_inflight, o_draining, o_err
    );
endinterface

// File: rtl/ysyx_24110006_scoreboard.sv
// Register scoreboard: per-register pending-write counters that stall decode on RAW
// hazards, on a full in-flight window, and while draining for serializing instructions.
module ysyx_24110006_scoreboard #(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input logic                       i_clock,
    input logic                       i_reset_n,
    ysyx_24110006_scoreboard_if.slave sb
);

    localparam logic [2:0] MaxInflight = 3'(MAX_INFLIGHT);

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q [1:31];
    logic [2:0] cnt_d [1:31];
    logic [2:0] cnt_rd [32];
    logic [2:0] inflight_q, inflight_d;
    logic       err_q, err_d;

    logic hazard, full, busy, stall, issue;
    logic inc, wb_req, wb_bad, dec;

    // x0 has no counter; a zero entry makes every lookup of it hazard-free.
    always_comb begin
        cnt_rd[0] = 3'd0;
        for (int r = 1; r < 32; r++) begin
            cnt_rd[r] = cnt_q[r];
        end
    end

    assign busy   = inflight_q != 3'd0;
    assign full   = inflight_q == MaxInflight;
    assign hazard = (sb.i_rs1_used && cnt_rd[sb.i_rs1] != 3'd0)
                 || (sb.i_rs2_used && cnt_rd[sb.i_rs2] != 3'd0);

    assign stall = sb.i_dec_valid
                && (hazard || full || (sb.i_serialize && busy)
                    || (state_q == StDrain && busy));
    assign issue = sb.i_dec_valid && sb.i_exu_ready && !stall && !sb.i_flush;

    assign inc    = issue && sb.i_rd_wen && sb.i_rd != 5'd0;
    assign wb_req = sb.i_wb_valid && sb.i_wb_wen && sb.i_wb_rd != 5'd0;
    // A retire with nothing outstanding is a pipeline bug: flag it, never underflow.
    assign wb_bad = wb_req && (cnt_rd[sb.i_wb_rd] == 3'd0 || !busy);
    assign dec    = wb_req && !wb_bad;

    always_comb begin
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc && sb.i_rd == 5'(r)) begin
                cnt_d[r] = cnt_d[r] + 3'd1;
            end
            if (dec && sb.i_wb_rd == 5'(r)) begin
                cnt_d[r] = cnt_d[r] - 3'd1;
            end
        end
        inflight_d = inflight_q + {2'b00, inc} - {2'b00, dec};
        err_d      = err_q || wb_bad;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (sb.i_dec_valid && sb.i_serialize && busy && !sb.i_flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!busy || sb.i_flush) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StRun;
            inflight_q <= 3'd0;
            err_q      <= 1'b0;
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= 3'd0;
            end
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign sb.o_stall    = stall;
    assign sb.o_issue    = issue;
    assign sb.o_inflight = inflight_q;
    assign sb.o_draining = state_q == StDrain;
    assign sb.o_err      = err_q;

endmodule

// File: tb/tb_ysyx_24110006_scoreboard.sv
// Scoreboard bench: a reference model queues expected outputs when inputs are driven;
// they are popped and compared when the DUT outputs are sampled.
module tb_ysyx_24110006_scoreboard;

    localparam int MAX = 4;

    logic i_clock = 1'b0;
    logic i_reset_n;

    ysyx_24110006_scoreboard_if sb ();

    ysyx_24110006_scoreboard #(.MAX_INFLIGHT(MAX)) dut (
        .i_clock  (i_clock),
        .i_reset_n(i_reset_n),
        .sb       (sb)
    );

    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic       stall;
        logic       issue;
        logic [2:0] inflight;
        logic       draining;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    int m_cnt [32];
    int m_infl;
    bit m_drain;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_infl  = 0;
        m_drain = 0;
        m_err   = 0;
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        bit   hz;
        bit   st;
        hz = (sb.i_rs1_used && sb.i_rs1 != 0 && m_cnt[sb.i_rs1] > 0)
          || (sb.i_rs2_used && sb.i_rs2 != 0 && m_cnt[sb.i_rs2] > 0);
        st = sb.i_dec_valid && (hz || m_infl == MAX || (sb.i_serialize && m_infl != 0)
                                || (m_drain && m_infl != 0));
        e.stall    = st;
        e.issue    = sb.i_dec_valid && sb.i_exu_ready && !st && !sb.i_flush;
        e.inflight = 3'(m_infl);
        e.draining = m_drain;
        e.err      = m_err;
        return e;
    endfunction

    task automatic eval();
        exp_t e;
        exp_q.push_back(model_exp());
        #1;
        e = exp_q.pop_front();
        check("stall", sb.o_stall, e.stall);
        check("issue", sb.o_issue, e.issue);
        check("inflight", sb.o_inflight, e.inflight);
        check("draining", sb.o_draining, e.draining);
        check("err", sb.o_err, e.err);
    endtask

    task automatic tick();
        exp_t e;
        int   old_infl;
        bit   up, wb, bad;
        @(posedge i_clock);
        e        = model_exp();
        old_infl = m_infl;
        up  = e.issue && sb.i_rd_wen && sb.i_rd != 0;
        wb  = sb.i_wb_valid && sb.i_wb_wen && sb.i_wb_rd != 0;
        bad = wb && (m_cnt[sb.i_wb_rd] == 0 || m_infl == 0);
        if (up) begin
            m_cnt[sb.i_rd] += 1;
            m_infl += 1;
        end
        if (wb && !bad) begin
            m_cnt[sb.i_wb_rd] -= 1;
            m_infl -= 1;
        end
        if (bad) m_err = 1;
        if (!m_drain) m_drain = sb.i_dec_valid && sb.i_serialize && old_infl != 0 && !sb.i_flush;
        else if (old_infl == 0 || sb.i_flush) m_drain = 0;
        @(negedge i_clock);
    endtask

    task automatic step();
        eval();
        tick();
    endtask

    task automatic idle();
        sb.i_dec_valid = 0;
        sb.i_rs1 = 0; sb.i_rs2 = 0; sb.i_rd = 0;
        sb.i_rs1_used = 0; sb.i_rs2_used = 0; sb.i_rd_wen = 0;
        sb.i_serialize = 0; sb.i_exu_ready = 1; sb.i_flush = 0;
        sb.i_wb_valid = 0; sb.i_wb_rd = 0; sb.i_wb_wen = 0;
    endtask

    task automatic set_dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input bit u1, input bit u2, input bit wen, input bit ser);
        sb.i_dec_valid = 1;
        sb.i_rs1 = rs1; sb.i_rs2 = rs2; sb.i_rd = rd;
        sb.i_rs1_used = u1; sb.i_rs2_used = u2; sb.i_rd_wen = wen;
        sb.i_serialize = ser;
    endtask

    task automatic set_wb(input logic [4:0] rd);
        sb.i_wb_valid = 1; sb.i_wb_wen = 1; sb.i_wb_rd = rd;
    endtask

    task automatic clr_wb();
        sb.i_wb_valid = 0; sb.i_wb_wen = 0; sb.i_wb_rd = 0;
    endtask

    initial begin
        int pend[$];
        idle();
        model_reset();
        i_reset_n = 0;
        @(negedge i_clock);
        eval();
        check("rst_inflight", sb.o_inflight, 0);
        check("rst_stall", sb.o_stall, 0);
        @(negedge i_clock);
        i_reset_n = 1;

        // RAW on rs1, then on rs2
        set_dec(0, 0, 5, 0, 0, 1, 0); eval(); check("raw_issue", sb.o_issue, 1); tick();
        set_dec(5, 0, 0, 1, 0, 0, 0); eval(); check("raw_stall", sb.o_stall, 1); tick();
        eval(); check("raw_hold", sb.o_stall, 1); tick();
        set_wb(5); eval(); check("raw_nobypass", sb.o_stall, 1); tick();
        clr_wb(); eval(); check("raw_release", sb.o_issue, 1); tick();
        set_dec(0, 0, 5, 0, 0, 1, 0); step();
        set_dec(0, 5, 0, 0, 1, 0, 0); eval(); check("raw2_stall", sb.o_stall, 1); tick();
        set_wb(5); step();
        clr_wb(); eval(); check("raw2_release", sb.o_issue, 1); tick();

        // Capacity
        for (int i = 1; i <= 4; i++) begin
            set_dec(0, 0, 5'(i), 0, 0, 1, 0); eval(); check("cap_fill", sb.o_issue, 1); tick();
        end
        set_dec(0, 0, 6, 0, 0, 1, 0); eval();
        check("cap_inflight", sb.o_inflight, 4); check("cap_stall", sb.o_stall, 1); tick();
        set_wb(1); eval(); check("cap_wb_stall", sb.o_stall, 1); tick();
        clr_wb(); eval(); check("cap_issue", sb.o_issue, 1); check("cap_infl3", sb.o_inflight, 3);
        tick();
        idle();
        foreach (pend[i]) pend.delete(i);
        pend = '{2, 3, 4, 6};
        foreach (pend[i]) begin
            set_wb(5'(pend[i])); step();
        end
        clr_wb(); eval(); check("cap_empty", sb.o_inflight, 0); tick();

        // Serialize / drain
        set_dec(0, 0, 8, 0, 0, 1, 0); step();
        set_dec(0, 0, 9, 0, 0, 1, 0); step();
        set_dec(0, 0, 0, 0, 0, 0, 1); eval();
        check("ser_infl", sb.o_inflight, 2); check("ser_stall", sb.o_stall, 1);
        check("ser_run", sb.o_draining, 0); tick();
        set_wb(8); eval(); check("ser_drain", sb.o_draining, 1); check("ser_stall2", sb.o_stall, 1);
        tick();
        set_wb(9); eval(); check("ser_infl1", sb.o_inflight, 1); check("ser_stall3", sb.o_stall, 1);
        tick();
        clr_wb(); eval(); check("ser_infl0", sb.o_inflight, 0); check("ser_issue", sb.o_issue, 1);
        check("ser_still_drain", sb.o_draining, 1); tick();
        idle(); eval(); check("ser_back_run", sb.o_draining, 0); tick();

        // Simultaneous issue and writeback to one register
        set_dec(0, 0, 7, 0, 0, 1, 0); step();
        set_wb(7); eval(); check("sim_issue", sb.o_issue, 1); tick();
        idle(); set_dec(7, 0, 0, 1, 0, 0, 0); eval();
        check("sim_infl", sb.o_inflight, 1); check("sim_cnt_kept", sb.o_stall, 1); tick();
        set_wb(7); step();
        clr_wb(); eval(); check("sim_release", sb.o_issue, 1); check("sim_infl0", sb.o_inflight, 0);
        tick();

        // x0 and underflow error
        set_dec(0, 0, 0, 0, 0, 1, 0); eval(); check("x0_issue", sb.o_issue, 1); tick();
        idle(); eval(); check("x0_infl", sb.o_inflight, 0); tick();
        set_dec(0, 0, 10, 0, 0, 1, 0); step();
        idle(); set_wb(3); eval(); check("err_before", sb.o_err, 0); tick();
        idle(); eval(); check("err_set", sb.o_err, 1); check("err_infl", sb.o_inflight, 1); tick();
        set_wb(10); step();
        idle(); eval(); check("err_sticky", sb.o_err, 1); check("err_infl0", sb.o_inflight, 0); tick();

        // Flush kills decode only and blocks entry to drain
        set_dec(0, 0, 12, 0, 0, 1, 0); sb.i_flush = 1; eval(); check("fl_noissue", sb.o_issue, 0);
        tick();
        sb.i_flush = 0; step();
        set_dec(0, 0, 0, 0, 0, 0, 1); sb.i_flush = 1; step();
        eval(); check("fl_nodrain", sb.o_draining, 0); check("fl_infl", sb.o_inflight, 1); tick();
        idle(); set_wb(12); step();
        idle();

        // Reset while draining
        for (int i = 11; i <= 13; i++) begin
            set_dec(0, 0, 5'(i), 0, 0, 1, 0); step();
        end
        set_dec(0, 0, 0, 0, 0, 0, 1); step();
        eval(); check("rd_drain", sb.o_draining, 1); check("rd_infl", sb.o_inflight, 3);
        i_reset_n = 0;
        #1;
        check("rd_infl0", sb.o_inflight, 0);
        check("rd_run", sb.o_draining, 0);
        check("rd_err0", sb.o_err, 0);
        model_reset();
        idle();
        @(negedge i_clock);
        i_reset_n = 1;

        // Random traffic against the model
        for (int c = 0; c < 500; c++) begin
            idle();
            if ($urandom_range(0, 3) != 0) begin
                set_dec(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 15) == 0);
            end
            sb.i_exu_ready = $urandom_range(0, 4) != 0;
            sb.i_flush     = $urandom_range(0, 9) == 0;
            pend.delete();
            for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) pend.push_back(r);
            if ($urandom_range(0, 39) == 0) begin
                set_wb(5'($urandom_range(0, 7)));
                sb.i_wb_wen = 1'($urandom_range(0, 1));
            end else if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                set_wb(5'(pend[$urandom_range(0, pend.size() - 1)]));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24110006_scoreboard.md
YSYX_24110006_SCOREBOARD -- requirements
Module: ysyx_24110006_scoreboard

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, meaning the maximum number of issued, not-yet-written-back register-writing instructions (legal range 1..7).
REQ-002 SHALL have port i_clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports i_dec_valid  input  1  decode stage holds a valid instruction.
REQ-005 SHALL have ports i_rs1, i_rs2, i_rd  input  5 each  source and destination register indices of the decoded instruction.
REQ-006 SHALL have ports i_rs1_used, i_rs2_used, i_rd_wen  input  1 each  source-read and destination-write enables.
REQ-007 SHALL have port i_serialize  input  1  instruction is CSR/mret/fence/ecall/ebreak and needs an empty pipeline.
REQ-008 SHALL have port i_exu_ready  input  1  execute stage accepts an instruction this cycle.
REQ-009 SHALL have port i_flush  input  1  redirect; kills the instruction in decode only.
REQ-010 SHALL have ports i_wb_valid  input  1, i_wb_rd  input  5, i_wb_wen  input  1  writeback retire event.
REQ-011 SHALL have port o_stall  output  1  decode must hold.
REQ-012 SHALL have port o_issue  output  1  instruction passes decode to execute this cycle.
REQ-013 SHALL have ports o_inflight  output  3  in-flight count; o_draining  output  1  FSM in DRAIN; o_err  output  1  sticky underflow error.

Function
REQ-014 SHALL keep one 3-bit pending counter per register x1..x31; x0 has no counter and always reads zero.
REQ-015 SHALL define hazard = (i_rs1_used & i_rs1!=0 & cnt[i_rs1]!=0) | (i_rs2_used & i_rs2!=0 & cnt[i_rs2]!=0), using registered counters only; a same-cycle writeback is not bypassed.
REQ-016 SHALL assert o_stall combinationally = i_dec_valid & (hazard | o_inflight==MAX_INFLIGHT | (i_serialize & o_inflight!=0)).
REQ-017 SHALL assert o_issue = i_dec_valid & i_exu_ready & !o_stall & !i_flush.
REQ-018 SHALL, on o_issue with i_rd_wen & i_rd!=0, increment cnt[i_rd] and o_inflight at the next edge.
REQ-019 SHALL, on i_wb_valid & i_wb_wen & i_wb_rd!=0, decrement cnt[i_wb_rd] and o_inflight at the next edge.
REQ-020 SHALL leave counters unchanged when issue and writeback target the same register in the same cycle; o_inflight likewise nets to zero change.
REQ-021 SHALL ignore i_rd_wen / i_wb_wen when the register index is 0.
REQ-022 SHALL, on a writeback to a register whose counter is 0 or while o_inflight is 0, not decrement either counter and set o_err, which holds until reset.
REQ-023 SHALL NOT clear counters on i_flush; issued instructions still write back.
REQ-024 SHALL implement FSM states RUN and DRAIN.
REQ-025 SHALL transition RUN->DRAIN when i_dec_valid & i_serialize & o_inflight!=0 & !i_flush.
REQ-026 SHALL transition DRAIN->RUN when o_inflight==0 or i_flush; in DRAIN o_stall stays asserted while o_inflight!=0.
REQ-027 SHALL drive o_draining=1 exactly when state is DRAIN.
REQ-028 SHALL issue a serializing instruction in the first cycle in which o_inflight==0, with no extra bubble.
REQ-029 SHALL produce o_stall/o_issue purely combinationally from inputs and registered state; counters and FSM update with one-cycle latency.

Reset
REQ-030 SHALL, while i_reset_n=0, asynchronously clear all counters, o_inflight=0, o_err=0, state=RUN; o_stall/o_issue then follow REQ-016/017 (0 when i_dec_valid=0).
REQ-031 SHALL discard any issue or writeback in progress when reset asserts mid-operation; no counter changes on the reset-release edge except from events sampled on that edge.

Verification
REQ-032 SHALL verify RAW: issue rd=5 wen; next cycle dec rs1=5 used -> o_stall=1 until the cycle after wb rd=5, then o_issue=1.
REQ-033 SHALL verify capacity: 4 issues to x1..x4 without writeback -> o_inflight=4, fifth independent instruction stalls; one wb -> issues the following cycle.
REQ-034 SHALL verify serialize: o_inflight=2, dec i_serialize=1 -> o_draining=1, o_stall=1; after two wbs o_inflight=0 -> same cycle o_issue=1, next cycle o_draining=0.
REQ-035 SHALL verify simultaneous: cnt[7]=1, issue rd=7 and wb rd=7 same cycle -> cnt[7]=1, o_inflight unchanged.
REQ-036 SHALL verify x0/error: issue rd=0 -> o_inflight unchanged; wb rd=3 with cnt[3]=0 -> o_err=1 sticky, counters unchanged.
REQ-037 SHALL verify reset: i_reset_n low mid-DRAIN with o_inflight=3 -> immediately o_inflight=0, o_draining=0, o_err=0.
